// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic arithmetic core.
// Mode/state encodings and a width-generic bit reversal.
package stoch_pkg;

    typedef enum logic [1:0] {
        MODE_MUL   = 2'b00,
        MODE_SADD  = 2'b01,
        MODE_ADIFF = 2'b10,
        MODE_MIN   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int MAX_W = 16;

    // Reverses the low w bits of v; bits at or above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_rev(
        input logic [MAX_W-1:0] v,
        input int               w
    );
        logic [MAX_W-1:0] r;
        int               j;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            j = w - 1 - i;
            if (i < w) r[i] = v[j[3:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/stoch_sng.sv
// Counter-based stream generator: emits (index < value), with the index
// optionally bit-reversed to decorrelate it from a linear-index stream.
module stoch_sng
    import stoch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] index,
    input  logic             rev_en,
    output logic             bit_o
);

    logic [MAX_W-1:0] idx_ext;
    logic [MAX_W-1:0] rev_ext;
    logic [WIDTH-1:0] idx;

    always_comb begin
        idx_ext             = '0;
        idx_ext[WIDTH-1:0]  = index;
        rev_ext             = bit_rev(idx_ext, WIDTH);
        idx                 = rev_en ? rev_ext[WIDTH-1:0] : index;
        bit_o               = (idx < value);
    end

endmodule

// File: rtl/stoch_arith_core.sv
// Stochastic arithmetic engine: two unary streams, one of four operators,
// and a ones-counter turning the output stream back into binary.
module stoch_arith_core
    import stoch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stream_bit
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic sa_bit;
    logic sb_bit;
    logic op_bit;
    logic b_rev;

    // Only MUL needs B decorrelated from A; the other operators rely on
    // both streams sharing the linear index.
    assign b_rev = (mode_q == MODE_MUL);

    stoch_sng #(.WIDTH(WIDTH)) u_sng_a (
        .value  (a_q),
        .index  (cnt_q),
        .rev_en (1'b0),
        .bit_o  (sa_bit)
    );

    stoch_sng #(.WIDTH(WIDTH)) u_sng_b (
        .value  (b_q),
        .index  (cnt_q),
        .rev_en (b_rev),
        .bit_o  (sb_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode_e'(mode);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + WIDTH'(stream_bit);
                cnt_d = cnt_q + WIDTH'(1);
                // Final bit folds straight into result on the exit edge.
                if (&cnt_q) begin
                    result_d = acc_d;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_bit = 1'b0;
        unique case (mode_q)
            MODE_MUL:   op_bit = sa_bit & sb_bit;
            MODE_SADD:  op_bit = cnt_q[0] ? sa_bit : sb_bit;
            MODE_ADIFF: op_bit = sa_bit ^ sb_bit;
            MODE_MIN:   op_bit = sa_bit & sb_bit;
            default:    op_bit = 1'b0;
        endcase
        stream_bit = (state_q == ST_RUN) & op_bit;
        busy       = (state_q == ST_RUN) | (state_q == ST_DONE);
        done       = (state_q == ST_DONE);
        result     = result_q;
    end

endmodule

// File: tb/tb_stoch_arith_core.sv
// Self-checking bench for stoch_arith_core at WIDTH=8 and WIDTH=4,
// compared against an arithmetic model of the stream operators.
module tb_stoch_arith_core;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [1:0] mode8;
    logic [7:0] a8, b8;
    logic       busy8, done8, sb8;
    logic [7:0] res8;

    logic       start4;
    logic [1:0] mode4;
    logic [3:0] a4, b4;
    logic       busy4, done4, sb4;
    logic [3:0] res4;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stoch_arith_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .result(res8), .stream_bit(sb8)
    );

    stoch_arith_core #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4),
        .a(a4), .b(b4), .busy(busy4), .done(done4),
        .result(res4), .stream_bit(sb4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int rev(input int v, input int w);
        int r = 0;
        for (int k = 0; k < w; k++) r = r * 2 + ((v >> k) & 1);
        return r;
    endfunction

    // Ones in the output stream, from the operator definitions.
    function automatic int model(input int w, input int a, input int b, input int m);
        int n = 1 << w;
        int c = 0;
        case (m)
            0: for (int i = 0; i < n; i++) if (i < a && rev(i, w) < b) c++;
            1: c = a / 2 + (b + 1) / 2;
            2: c = (a > b) ? a - b : b - a;
            default: c = (a < b) ? a : b;
        endcase
        return c;
    endfunction

    task automatic run(input bit w4, input int a, input int b, input int m,
                       output int lat, output int res, output int ones);
        @(negedge clk);
        if (w4) begin
            a4 = a[3:0]; b4 = b[3:0]; mode4 = m[1:0]; start4 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; mode8 = m[1:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        ones = w4 ? int'(sb4) : int'(sb8);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!(w4 ? done4 : done8)) ones += (w4 ? int'(sb4) : int'(sb8));
        end while (!(w4 ? done4 : done8) && lat < 600);
        res = w4 ? int'(res4) : int'(res8);
    endtask

    task automatic check_run(input string tag, input bit w4, input int a, input int b, input int m);
        int lat, res, ones, exp_v, n;
        n = w4 ? 16 : 256;
        exp_v = model(w4 ? 4 : 8, a, b, m);
        run(w4, a, b, m, lat, res, ones);
        chk($sformatf("%s latency", tag), lat, n);
        chk($sformatf("%s result a=%0d b=%0d m=%0d", tag, a, b, m), res, exp_v);
        chk($sformatf("%s stream ones", tag), ones, exp_v);
        @(posedge clk);
        #1;
        chk($sformatf("%s done pulse", tag), w4 ? done4 : done8, 0);
        chk($sformatf("%s busy idle", tag), w4 ? busy4 : busy8, 0);
    endtask

    initial begin
        int t, dn, r, lat, ones;
        rst = 1'b1;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        start4 = 0; mode4 = 0; a4 = 0; b4 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy8, 0);
        chk("rst done", done8, 0);
        chk("rst result", res8, 0);
        chk("rst stream", sb8, 0);
        chk("rst result w4", res4, 0);
        @(negedge clk);
        rst = 1'b0;

        check_run("mul_half", 0, 128, 128, 0);
        check_run("mul_full", 0, 255, 37, 0);
        check_run("mul_zero", 0, 0, 200, 0);
        check_run("sadd", 0, 255, 0, 1);
        check_run("adiff", 0, 200, 55, 2);
        check_run("min", 0, 90, 170, 3);
        check_run("min_w4", 1, 15, 9, 3);

        // Restart attempt mid-run must be ignored.
        @(negedge clk);
        a8 = 200; b8 = 100; mode8 = 2'd3; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        a8 = 10; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        dn = 0; r = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done8) begin dn++; r = res8; end
        end
        chk("midrun done count", dn, 1);
        chk("midrun result", r, model(8, 200, 100, 3));

        // Start held high: back-to-back runs.
        @(negedge clk);
        a8 = 128; b8 = 128; mode8 = 2'd0; start8 = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!done8 && t < 600);
        chk("held first done", t, 257);
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!done8 && t < 600);
        start8 = 1'b0;
        chk("held gap", t, 258);
        chk("held result", res8, 64);
        @(posedge clk);
        #1;

        // Async reset in the middle of a run.
        @(negedge clk);
        a8 = 255; b8 = 255; mode8 = 2'd3; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        chk("pre-rst stream", sb8, 1);
        chk("pre-rst busy", busy8, 1);
        rst = 1'b1;
        #1;
        chk("async rst busy", busy8, 0);
        chk("async rst done", done8, 0);
        chk("async rst result", res8, 0);
        chk("async rst stream", sb8, 0);
        @(negedge clk);
        rst = 1'b0;
        check_run("post-rst adiff", 0, 200, 55, 2);

        for (int i = 0; i < 16; i++)
            check_run("rand8", 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
        for (int i = 0; i < 40; i++)
            check_run("rand4", 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                run(1, x, y, 2, lat, r, ones);
                chk($sformatf("sweep adiff %0d %0d", x, y), r, model(4, x, y, 2));
                @(posedge clk);
                run(1, x, y, 3, lat, r, ones);
                chk($sformatf("sweep min %0d %0d", x, y), r, model(4, x, y, 3));
                @(posedge clk);
            end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
